// File: rtl/reg_bank_8x16_wr_pkg.sv
// Shared constants for the 8x16 register bank write path and its 8:1 read mux.
//   WORD_W    : data width of one entry (16)
//   SEL_BITS  : entry select width (3)
//   REG_CNT   : number of entries (8)
//   WORD_ZERO : reset value of an entry
//   wr_req_t  : one staged write request (target entry + data)
package reg_bank_8x16_wr_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned SEL_BITS = 3;
  localparam int unsigned REG_CNT  = 1 << SEL_BITS;

  localparam logic [WORD_W-1:0] WORD_ZERO = '0;

  typedef struct packed {
    logic [SEL_BITS-1:0] sel;
    logic [WORD_W-1:0]   data;
  } wr_req_t;

endpackage

// File: rtl/reg_bank_8x16_wr_dec_3to8.sv
// One-hot select decoder (3:8 at the default width).
// Drives the per-entry commit enables of the register bank.
// Ports:
//   en     in  1            decode enable; all outputs low when 0
//   sel    in  SEL_W        entry index
//   onehot out 2**SEL_W     one-hot enable, combinational
module reg_bank_8x16_wr_dec_3to8
  import reg_bank_8x16_wr_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_BITS
) (
  input  logic                    en,
  input  logic [SEL_W-1:0]        sel,
  output logic [(2**SEL_W)-1:0]   onehot
);

  // Full decode: every sel value maps to exactly one bit.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_bank_8x16_wr.sv
// 8-entry x 16-bit register bank, write side of the 8:1 selection path.
// A write is captured into a staging register on one edge and committed to
// the addressed entry on the next edge.
// Optional feature macro: WR_FWD_EN -- when defined, a staged write is
// forwarded combinationally onto its outN so it is visible one edge after
// capture; when undefined, outN is a pure register (two-edge visibility).
// Ports:
//   clk        in   1         clock, all state on posedge
//   rst_n      in   1         synchronous reset, active low
//   wr_en      in   1         write request
//   wr_sel     in   SEL_W     target entry (0 = out1 ... 7 = out8)
//   wr_data    in   WIDTH     write data
//   out1..out8 out  WIDTH     entry contents, feed the 8:1 read mux
//   written    out  2**SEL_W  sticky per-entry written flags
//   pend_vld   out  1         staging register holds an uncommitted write
//   pend_sel   out  SEL_W     target entry of the staged write
module reg_bank_8x16_wr
  import reg_bank_8x16_wr_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned SEL_W = SEL_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [SEL_W-1:0]      wr_sel,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      out1,
  output logic [WIDTH-1:0]      out2,
  output logic [WIDTH-1:0]      out3,
  output logic [WIDTH-1:0]      out4,
  output logic [WIDTH-1:0]      out5,
  output logic [WIDTH-1:0]      out6,
  output logic [WIDTH-1:0]      out7,
  output logic [WIDTH-1:0]      out8,
  output logic [(2**SEL_W)-1:0] written,
  output logic                  pend_vld,
  output logic [SEL_W-1:0]      pend_sel
);

  localparam int unsigned NUM = 2**SEL_W;

  logic [WIDTH-1:0] pend_data;
  logic [NUM-1:0]   commit_oh;
  logic [WIDTH-1:0] entry_q [NUM];
  logic [WIDTH-1:0] rd      [NUM];

  // Capture stage: valid follows wr_en every edge, payload holds when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      pend_sel  <= '0;
      pend_data <= WIDTH'(WORD_ZERO);
    end else begin
      pend_vld <= wr_en;
      if (wr_en) begin
        pend_sel  <= wr_sel;
        pend_data <= wr_data;
      end
    end
  end

  // Commit enables come from the staged select, not the live input.
  reg_bank_8x16_wr_dec_3to8 #(
    .SEL_W (SEL_W)
  ) u_dec (
    .en     (pend_vld),
    .sel    (pend_sel),
    .onehot (commit_oh)
  );

  // Commit stage: only the decoded entry loads; reset drops any staged write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) begin
        entry_q[i] <= WIDTH'(WORD_ZERO);
      end
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (commit_oh[i]) begin
          entry_q[i] <= pend_data;
        end
      end
    end
  end

  // Written flags are sticky until reset and track commits, not captures.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      written <= '0;
    end else begin
      written <= written | commit_oh;
    end
  end

`ifdef WR_FWD_EN
  // Staged data overrides the stored entry it is about to replace.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      rd[i] = entry_q[i];
      if (pend_vld && (pend_sel == SEL_W'(i))) begin
        rd[i] = pend_data;
      end
    end
  end
`else
  // Registered outputs only; no path from staging to outN.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      rd[i] = entry_q[i];
    end
  end
`endif

  assign out1 = rd[0];
  assign out2 = rd[1];
  assign out3 = rd[2];
  assign out4 = rd[3];
  assign out5 = rd[4];
  assign out6 = rd[5];
  assign out7 = rd[6];
  assign out8 = rd[7];

endmodule
